// File: rtl/conv3x3_window_if.sv
// -----------------------------------------------------------------------------
// conv3x3_window_if
//   Column-in / pixel-out bundle for the 3x3 convolution window.
//
//   Handshake: valid-only streaming, no ready and no backpressure. The
//   producer asserts data_valid_in for exactly the cycles in which data_in,
//   hcount_in, vcount_in and kernel_sel_in carry a column. The block asserts
//   data_valid_out for exactly one cycle per filtered pixel. While
//   data_valid_out is low, pixel_out, hcount_out and vcount_out hold their
//   last values.
//
//   Signals:
//     data_in        [2:0][7:0] column: [0] row above, [1] centre row, [2] row below
//     hcount_in      [10:0]     column index of data_in
//     vcount_in      [9:0]      centre-row index of data_in
//     data_valid_in             column valid this cycle
//     kernel_sel_in  [1:0]      0 identity, 1 Gaussian, 2 sharpen, 3 |Sobel-x|
//     pixel_out      [7:0]      filtered pixel
//     hcount_out     [10:0]     column of the window centre
//     vcount_out     [9:0]      row of the window centre
//     data_valid_out            one-cycle pulse per output pixel
//
//   Modports: master = column producer / pixel consumer, slave = the filter.
// -----------------------------------------------------------------------------
interface conv3x3_window_if;
  logic [2:0][7:0] data_in;
  logic [10:0]     hcount_in;
  logic [9:0]      vcount_in;
  logic            data_valid_in;
  logic [1:0]      kernel_sel_in;
  logic [7:0]      pixel_out;
  logic [10:0]     hcount_out;
  logic [9:0]      vcount_out;
  logic            data_valid_out;

  modport master (
    output data_in, hcount_in, vcount_in, data_valid_in, kernel_sel_in,
    input  pixel_out, hcount_out, vcount_out, data_valid_out
  );

  modport slave (
    input  data_in, hcount_in, vcount_in, data_valid_in, kernel_sel_in,
    output pixel_out, hcount_out, vcount_out, data_valid_out
  );
endinterface

// File: rtl/conv3x3_window.sv
// -----------------------------------------------------------------------------
// conv3x3_window
//   Assembles a 3x3 window from a stream of vertical 3-pixel columns coming
//   out of the line buffer, applies a per-pixel selectable kernel and emits
//   one filtered 8-bit pixel with its centre coordinates. Edges are handled
//   by replication: top/bottom rows inside the column, left column on the
//   hcount==0 load, right column by a one-cycle flush after the last column.
//   Output latency is 3 cycles from the cycle a pixel is issued.
//
//   Parameters:
//     HRES  active pixels per line
//     VRES  active lines per frame
//
//   Ports:
//     clk_in  system clock
//     rst_in  asynchronous active-high reset (clears outputs, window,
//             pipeline and pending flush)
//     bus     conv3x3_window_if.slave (column in, filtered pixel out)
//
//   Build option:
//     CONV_BORDER_ZERO_EN  when defined, pixels centred on the frame border
//                          output 0 (timing and coordinates unchanged).
// -----------------------------------------------------------------------------
module conv3x3_window #(
  parameter int HRES = 640,
  parameter int VRES = 380
) (
  input  logic             clk_in,
  input  logic             rst_in,
  conv3x3_window_if.slave  bus
);

  typedef logic [2:0][7:0] col_t;

  localparam logic [10:0] H_LAST = 11'(HRES - 1);
  localparam logic [9:0]  V_LAST = 10'(VRES - 1);

  function automatic logic signed [12:0] to_s(input logic [7:0] p);
    return $signed({5'd0, p});
  endfunction

  // ---------------------------------------------------------------------------
  // Vertical edge replication of the incoming column
  // ---------------------------------------------------------------------------
  col_t col_in;

  always_comb begin
    col_in = bus.data_in;
    if (bus.vcount_in == '0)    col_in[0] = bus.data_in[1];
    if (bus.vcount_in == V_LAST) col_in[2] = bus.data_in[1];
  end

  // ---------------------------------------------------------------------------
  // Window and issue logic
  //   After a shift the window is {old W1, old W2, new column}, so the left
  //   column of an issued pixel is always the current W1 and W0 never needs
  //   its own register. The flush pixel uses W1 | W2 | W2 (right column
  //   replicated), centred on the last column of the line.
  // ---------------------------------------------------------------------------
  col_t        w1_q, w1_d;
  col_t        w2_q, w2_d;
  logic        flush_q, flush_d;
  logic [9:0]  flush_v_q, flush_v_d;
  logic [1:0]  flush_k_q, flush_k_d;

  logic        issue;
  col_t        tap_l, tap_c, tap_r;
  logic [10:0] iss_h;
  logic [9:0]  iss_v;
  logic [1:0]  iss_k;

  always_comb begin
    w1_d      = w1_q;
    w2_d      = w2_q;
    flush_d   = 1'b0;
    flush_v_d = flush_v_q;
    flush_k_d = flush_k_q;
    // Defaults describe the flush pixel; a normal issue overrides them.
    issue     = flush_q;
    tap_l     = w1_q;
    tap_c     = w2_q;
    tap_r     = w2_q;
    iss_h     = H_LAST;
    iss_v     = flush_v_q;
    iss_k     = flush_k_q;

    if (bus.data_valid_in) begin
      if (bus.hcount_in == '0) begin
        // Left edge: replicate the first column into centre and right. The
        // flush, if pending, already read the pre-update window above.
        w1_d = col_in;
        w2_d = col_in;
      end else begin
        w1_d = w2_q;
        w2_d = col_in;
        if (!flush_q) begin
          issue = 1'b1;
          tap_r = col_in;
          iss_h = bus.hcount_in - 11'd1;
          iss_v = bus.vcount_in;
          iss_k = bus.kernel_sel_in;
        end
      end
      if (bus.hcount_in == H_LAST) begin
        // The kernel is latched with the last column so the flush pixel
        // filters with the selection presented alongside its data.
        flush_d   = 1'b1;
        flush_v_d = bus.vcount_in;
        flush_k_d = bus.kernel_sel_in;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      w1_q      <= '0;
      w2_q      <= '0;
      flush_q   <= 1'b0;
      flush_v_q <= '0;
      flush_k_q <= '0;
    end else begin
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      flush_q   <= flush_d;
      flush_v_q <= flush_v_d;
      flush_k_q <= flush_k_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: taps, kernel select and coordinates
  // ---------------------------------------------------------------------------
  logic        s1_valid_q;
  col_t        s1_l_q, s1_c_q, s1_r_q;
  logic [1:0]  s1_k_q;
  logic [10:0] s1_h_q;
  logic [9:0]  s1_v_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_l_q     <= '0;
      s1_c_q     <= '0;
      s1_r_q     <= '0;
      s1_k_q     <= '0;
      s1_h_q     <= '0;
      s1_v_q     <= '0;
    end else begin
      s1_valid_q <= issue;
      if (issue) begin
        s1_l_q <= tap_l;
        s1_c_q <= tap_c;
        s1_r_q <= tap_r;
        s1_k_q <= iss_k;
        s1_h_q <= iss_h;
        s1_v_q <= iss_v;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: signed weighted sum. 13 bits covers Gaussian max 16*255 = 4080 and
  // the sharpen/Sobel range of -1020..1275.
  // ---------------------------------------------------------------------------
  logic signed [12:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic signed [12:0] sum_d;

  assign p00 = to_s(s1_l_q[0]);
  assign p01 = to_s(s1_c_q[0]);
  assign p02 = to_s(s1_r_q[0]);
  assign p10 = to_s(s1_l_q[1]);
  assign p11 = to_s(s1_c_q[1]);
  assign p12 = to_s(s1_r_q[1]);
  assign p20 = to_s(s1_l_q[2]);
  assign p21 = to_s(s1_c_q[2]);
  assign p22 = to_s(s1_r_q[2]);

  always_comb begin
    sum_d = p11;
    case (s1_k_q)
      2'd1: sum_d = p00 + (p01 <<< 1) + p02
                  + (p10 <<< 1) + (p11 <<< 2) + (p12 <<< 1)
                  + p20 + (p21 <<< 1) + p22;
      2'd2: sum_d = (p11 <<< 2) + p11 - p01 - p10 - p12 - p21;
      2'd3: sum_d = (p02 - p00) + ((p12 - p10) <<< 1) + (p22 - p20);
      default: sum_d = p11;
    endcase
  end

  logic               s2_valid_q;
  logic signed [12:0] s2_sum_q;
  logic [1:0]         s2_k_q;
  logic [10:0]        s2_h_q;
  logic [9:0]         s2_v_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_k_q     <= '0;
      s2_h_q     <= '0;
      s2_v_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_q <= sum_d;
        s2_k_q   <= s1_k_q;
        s2_h_q   <= s1_h_q;
        s2_v_q   <= s1_v_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: normalise / clamp into the output register
  // ---------------------------------------------------------------------------
  logic signed [12:0] g_rnd;
  logic signed [12:0] s_abs;
  logic [7:0]         pix_d;

  always_comb begin
    g_rnd = s2_sum_q + 13'sd8;
    s_abs = s2_sum_q[12] ? -s2_sum_q : s2_sum_q;
    pix_d = s2_sum_q[7:0];
    case (s2_k_q)
      2'd1: pix_d = 8'(g_rnd >>> 4);
      2'd2: begin
        if (s2_sum_q[12])               pix_d = 8'd0;
        else if (s2_sum_q > 13'sd255)   pix_d = 8'd255;
        else                            pix_d = s2_sum_q[7:0];
      end
      2'd3: pix_d = (s_abs > 13'sd255) ? 8'd255 : s_abs[7:0];
      default: pix_d = s2_sum_q[7:0];
    endcase
`ifdef CONV_BORDER_ZERO_EN
    if (s2_h_q == '0 || s2_h_q == H_LAST || s2_v_q == '0 || s2_v_q == V_LAST)
      pix_d = 8'd0;
`endif
  end

  logic        valid_out_q;
  logic [7:0]  pix_out_q;
  logic [10:0] h_out_q;
  logic [9:0]  v_out_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_out_q <= 1'b0;
      pix_out_q   <= '0;
      h_out_q     <= '0;
      v_out_q     <= '0;
    end else begin
      valid_out_q <= s2_valid_q;
      if (s2_valid_q) begin
        pix_out_q <= pix_d;
        h_out_q   <= s2_h_q;
        v_out_q   <= s2_v_q;
      end
    end
  end

  assign bus.data_valid_out = valid_out_q;
  assign bus.pixel_out      = pix_out_q;
  assign bus.hcount_out     = h_out_q;
  assign bus.vcount_out     = v_out_q;

endmodule

// File: tb/tb_conv3x3_window.sv
// -----------------------------------------------------------------------------
// tb_conv3x3_window
//   Directed bench for conv3x3_window on an 8x4 frame. Columns are driven on
//   the falling edge; a monitor logs every valid output (pixel, coordinates,
//   cycle) on the falling edge. Each scenario task drives its frame and then
//   checks the logged outputs against hand-derived values, including the
//   3-cycle issue-to-output latency (4 cycles after the last column of a
//   line, which is issued by the flush). Rows outside the frame are driven
//   with garbage so vertical replication is exercised.
// -----------------------------------------------------------------------------
module tb_conv3x3_window;

  localparam int HRES = 8;
  localparam int VRES = 4;
  localparam int NPIX = HRES * VRES;

`ifdef CONV_BORDER_ZERO_EN
  localparam bit BORDER_ZERO = 1'b1;
`else
  localparam bit BORDER_ZERO = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   cyc    = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  conv3x3_window_if bus ();

  conv3x3_window #(.HRES(HRES), .VRES(VRES)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // ---------------------------------------------------------------------------
  // Stimulus state and output log
  // ---------------------------------------------------------------------------
  int         img [VRES][HRES];
  int         in_cyc [2][VRES][HRES];
  int         fr;
  logic [7:0] got_pix[$];
  int         got_h[$], got_v[$], got_c[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  always @(negedge clk_in) begin
    if (bus.data_valid_out === 1'b1) begin
      got_pix.push_back(bus.pixel_out);
      got_h.push_back(int'(bus.hcount_out));
      got_v.push_back(int'(bus.vcount_out));
      got_c.push_back(cyc);
    end
  end

  function automatic bit is_border(input int h, input int v);
    return BORDER_ZERO && (h == 0 || h == HRES - 1 || v == 0 || v == VRES - 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clear_mon();
    got_pix.delete();
    got_h.delete();
    got_v.delete();
    got_c.delete();
  endtask

  task automatic drive_col(input int h, input int v, input logic [1:0] k);
    @(negedge clk_in);
    if (v == 0) bus.data_in[0] = 8'hA5;
    else        bus.data_in[0] = 8'(img[v-1][h]);
    bus.data_in[1] = 8'(img[v][h]);
    if (v == VRES - 1) bus.data_in[2] = 8'h5A;
    else               bus.data_in[2] = 8'(img[v+1][h]);
    bus.hcount_in     = 11'(h);
    bus.vcount_in     = 10'(v);
    bus.kernel_sel_in = k;
    bus.data_valid_in = 1'b1;
    in_cyc[fr][v][h]  = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      bus.data_valid_in = 1'b0;
      bus.hcount_in     = 11'($urandom_range(0, HRES - 1));
      bus.kernel_sel_in = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic drive_frame(input logic [1:0] k, input int max_gap);
    for (int v = 0; v < VRES; v++) begin
      for (int h = 0; h < HRES; h++) begin
        drive_col(h, v, k);
        if (max_gap > 0) idle($urandom_range(0, max_gap));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    n_cmp++;
    if (bus.data_valid_out !== 1'b0 || bus.pixel_out !== 8'd0 ||
        bus.hcount_out !== 11'd0 || bus.vcount_out !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b p=%0d h=%0d y=%0d, expected all 0",
               bus.data_valid_out, bus.pixel_out, bus.hcount_out, bus.vcount_out);
    end
    rst_in = 1'b0;
    clear_mon();
    idle(6);
    n_cmp++;
    if (got_pix.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d outputs with no input, expected 0", got_pix.size());
    end
  endtask

  task automatic test_gaussian();
    int eh, ev, ec, ep;
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++) img[v][h] = 100;
    clear_mon();
    fr = 0;
    drive_frame(2'd1, 0);
    idle(8);
    n_cmp++;
    if (got_pix.size() != NPIX) begin
      n_fail++;
      $display("FAIL gauss_count: got %0d outputs, expected %0d", got_pix.size(), NPIX);
    end
    for (int i = 0; i < got_pix.size() && i < NPIX; i++) begin
      eh = i % HRES;
      ev = i / HRES;
      ec = (eh == HRES - 1) ? in_cyc[0][ev][eh] + 4 : in_cyc[0][ev][eh+1] + 3;
      ep = is_border(eh, ev) ? 0 : 100;
      n_cmp++;
      if (got_h[i] !== eh || got_v[i] !== ev || got_c[i] !== ec) begin
        n_fail++;
        $display("FAIL gauss_pos[%0d]: got (%0d,%0d)@%0d, expected (%0d,%0d)@%0d",
                 i, got_h[i], got_v[i], got_c[i], eh, ev, ec);
      end
      n_cmp++;
      if (got_pix[i] !== 8'(ep)) begin
        n_fail++;
        $display("FAIL gauss_pix(%0d,%0d): got %0d, expected %0d", eh, ev, got_pix[i], ep);
      end
    end
  endtask

  task automatic test_identity_ramp();
    int eh, ev, ec, ep;
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++) img[v][h] = h * 10;
    clear_mon();
    fr = 0;
    drive_frame(2'd0, 2);
    idle(8);
    n_cmp++;
    if (got_pix.size() != NPIX) begin
      n_fail++;
      $display("FAIL ramp_count: got %0d outputs, expected %0d", got_pix.size(), NPIX);
    end
    for (int i = 0; i < got_pix.size() && i < NPIX; i++) begin
      eh = i % HRES;
      ev = i / HRES;
      ec = (eh == HRES - 1) ? in_cyc[0][ev][eh] + 4 : in_cyc[0][ev][eh+1] + 3;
      ep = is_border(eh, ev) ? 0 : eh * 10;
      n_cmp++;
      if (got_h[i] !== eh || got_v[i] !== ev || got_c[i] !== ec) begin
        n_fail++;
        $display("FAIL ramp_pos[%0d]: got (%0d,%0d)@%0d, expected (%0d,%0d)@%0d",
                 i, got_h[i], got_v[i], got_c[i], eh, ev, ec);
      end
      n_cmp++;
      if (got_pix[i] !== 8'(ep)) begin
        n_fail++;
        $display("FAIL ramp_pix(%0d,%0d): got %0d, expected %0d", eh, ev, got_pix[i], ep);
      end
    end
  endtask

  task automatic test_sharpen_impulse();
    int eh, ev, ep;
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++) img[v][h] = 0;
    img[2][3] = 255;
    clear_mon();
    fr = 0;
    drive_frame(2'd2, 0);
    idle(8);
    n_cmp++;
    if (got_pix.size() != NPIX) begin
      n_fail++;
      $display("FAIL sharpen_count: got %0d outputs, expected %0d", got_pix.size(), NPIX);
    end
    for (int i = 0; i < got_pix.size() && i < NPIX; i++) begin
      eh = i % HRES;
      ev = i / HRES;
      ep = (eh == 3 && ev == 2) ? 255 : 0;
      n_cmp++;
      if (got_h[i] !== eh || got_v[i] !== ev || got_pix[i] !== 8'(ep)) begin
        n_fail++;
        $display("FAIL sharpen(%0d,%0d): got (%0d,%0d)=%0d, expected %0d",
                 eh, ev, got_h[i], got_v[i], got_pix[i], ep);
      end
    end
  endtask

  task automatic test_sobel_step();
    int eh, ev, ep;
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++) img[v][h] = (h >= 4) ? 200 : 0;
    clear_mon();
    fr = 0;
    drive_frame(2'd3, 0);
    idle(8);
    n_cmp++;
    if (got_pix.size() != NPIX) begin
      n_fail++;
      $display("FAIL sobel_count: got %0d outputs, expected %0d", got_pix.size(), NPIX);
    end
    for (int i = 0; i < got_pix.size() && i < NPIX; i++) begin
      eh = i % HRES;
      ev = i / HRES;
      ep = ((eh == 3 || eh == 4) && !is_border(eh, ev)) ? 255 : 0;
      n_cmp++;
      if (got_h[i] !== eh || got_v[i] !== ev || got_pix[i] !== 8'(ep)) begin
        n_fail++;
        $display("FAIL sobel(%0d,%0d): got (%0d,%0d)=%0d, expected %0d",
                 eh, ev, got_h[i], got_v[i], got_pix[i], ep);
      end
    end
  endtask

  // Two frames with no gap: identity on a 2-D ramp, then Gaussian on a
  // constant frame. The last flush of frame 0 lands on frame 1's first load
  // while kernel_sel_in already selects Gaussian.
  task automatic test_back_to_back();
    int eh, ev, ef, ec, ep;
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++) img[v][h] = v * 40 + h * 5 + 20;
    clear_mon();
    fr = 0;
    drive_frame(2'd0, 0);
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++) img[v][h] = 100;
    fr = 1;
    drive_frame(2'd1, 0);
    idle(8);
    n_cmp++;
    if (got_pix.size() != 2 * NPIX) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d outputs, expected %0d", got_pix.size(), 2 * NPIX);
    end
    for (int i = 0; i < got_pix.size() && i < 2 * NPIX; i++) begin
      ef = i / NPIX;
      eh = (i % NPIX) % HRES;
      ev = (i % NPIX) / HRES;
      ec = (eh == HRES - 1) ? in_cyc[ef][ev][eh] + 4 : in_cyc[ef][ev][eh+1] + 3;
      if (is_border(eh, ev)) ep = 0;
      else if (ef == 0)      ep = ev * 40 + eh * 5 + 20;
      else                   ep = 100;
      n_cmp++;
      if (got_h[i] !== eh || got_v[i] !== ev || got_c[i] !== ec) begin
        n_fail++;
        $display("FAIL b2b_pos[%0d]: got (%0d,%0d)@%0d, expected (%0d,%0d)@%0d",
                 i, got_h[i], got_v[i], got_c[i], eh, ev, ec);
      end
      n_cmp++;
      if (got_pix[i] !== 8'(ep)) begin
        n_fail++;
        $display("FAIL b2b_pix f%0d(%0d,%0d): got %0d, expected %0d",
                 ef, eh, ev, got_pix[i], ep);
      end
    end
  endtask

  // Reset between clock edges just after the last column of a line: the
  // pending flush and in-flight pixels must vanish, then a fresh frame
  // (constant 100, Gaussian) checks recovery and the border option.
  task automatic test_async_reset();
    int eh, ev, ec, ep;
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++) img[v][h] = 100;
    clear_mon();
    fr = 0;
    for (int v = 0; v < 2; v++)
      for (int h = 0; h < HRES; h++) drive_col(h, v, 2'd1);
    @(posedge clk_in);
    #1;
    n_cmp++;
    if (bus.data_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got data_valid_out=%b, expected 1", bus.data_valid_out);
    end
    #1;
    rst_in = 1'b1;
    bus.data_valid_in = 1'b0;
    #1;
    n_cmp++;
    if (bus.data_valid_out !== 1'b0 || bus.pixel_out !== 8'd0 ||
        bus.hcount_out !== 11'd0 || bus.vcount_out !== 10'd0) begin
      n_fail++;
      $display("FAIL areset_drop: got v=%b p=%0d h=%0d y=%0d, expected all 0",
               bus.data_valid_out, bus.pixel_out, bus.hcount_out, bus.vcount_out);
    end
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    clear_mon();
    idle(10);
    n_cmp++;
    if (got_pix.size() != 0) begin
      n_fail++;
      $display("FAIL areset_quiet: got %0d outputs after reset, expected 0", got_pix.size());
    end
    clear_mon();
    fr = 0;
    drive_frame(2'd1, 0);
    idle(8);
    n_cmp++;
    if (got_pix.size() != NPIX) begin
      n_fail++;
      $display("FAIL areset_count: got %0d outputs, expected %0d", got_pix.size(), NPIX);
    end
    for (int i = 0; i < got_pix.size() && i < NPIX; i++) begin
      eh = i % HRES;
      ev = i / HRES;
      ec = (eh == HRES - 1) ? in_cyc[0][ev][eh] + 4 : in_cyc[0][ev][eh+1] + 3;
      ep = is_border(eh, ev) ? 0 : 100;
      n_cmp++;
      if (got_h[i] !== eh || got_v[i] !== ev || got_c[i] !== ec || got_pix[i] !== 8'(ep)) begin
        n_fail++;
        $display("FAIL areset_frame[%0d]: got (%0d,%0d)@%0d=%0d, expected (%0d,%0d)@%0d=%0d",
                 i, got_h[i], got_v[i], got_c[i], got_pix[i], eh, ev, ec, ep);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    bus.data_in       = '0;
    bus.hcount_in     = '0;
    bus.vcount_in     = '0;
    bus.data_valid_in = 1'b0;
    bus.kernel_sel_in = '0;
    fr                = 0;

    test_reset();
    test_gaussian();
    test_identity_ramp();
    test_sharpen_impulse();
    test_sobel_step();
    test_back_to_back();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
